// File: rtl/s65nllhs2ph_64x8.sv
// Two-port register file: registered read on port A, bit-masked write on port B.
// The asynchronous reset clears both the storage array and the read register.
module s65nllhs2ph_64x8 #(
   parameter int Bits       = 8,
   parameter int Word_Depth = 64,
   parameter int Add_Width  = 6,
   parameter int Wen_Width  = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CENA,
   input  logic [Add_Width-1:0] AA,
   output logic [Bits-1:0]      QA,
   input  logic                 CENB,
   input  logic [Wen_Width-1:0] BWENB,
   input  logic [Add_Width-1:0] AB,
   input  logic [Bits-1:0]      DB
);

   logic [Bits-1:0] mem_r [Word_Depth];
   logic [Bits-1:0] qa_r;
   logic [Bits-1:0] rd_word_s;
   logic [Word_Depth-1:0] we_s;

   // Word-select decode; out-of-range write addresses never match a word.
   always_comb begin
      we_s = '0;
      for (int i = 0; i < Word_Depth; i++) begin
         if (CENB && (AB == i[Add_Width-1:0])) begin
            we_s[i] = 1'b1;
         end else begin
            we_s[i] = 1'b0;
         end
      end
   end

   // Read mux; out-of-range read addresses return zero.
   always_comb begin
      rd_word_s = '0;
      for (int i = 0; i < Word_Depth; i++) begin
         if (AA == i[Add_Width-1:0]) begin
            rd_word_s = mem_r[i];
         end else begin
            rd_word_s = rd_word_s;
         end
      end
   end

   // Storage array with per-bit masked update.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < Word_Depth; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < Word_Depth; i++) begin
            if (we_s[i]) begin
               mem_r[i] <= (mem_r[i] & ~BWENB) | (DB & BWENB);
            end
         end
      end
   end

   // Read register samples pre-write contents, giving read-before-write on collision.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         qa_r <= '0;
      end else if (CENA) begin
         qa_r <= rd_word_s;
      end
   end

   assign QA = qa_r;

endmodule

// File: tb/tb_s65nllhs2ph_64x8.sv
// Directed-vector bench for s65nllhs2ph_64x8 with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_s65nllhs2ph_64x8;

   logic       clk;
   logic       rst;
   logic       cena;
   logic [5:0] aa;
   logic [7:0] qa;
   logic       cenb;
   logic [7:0] bwenb;
   logic [5:0] ab;
   logic [7:0] db;
   logic       chk_en;

   logic [7:0] exp_q [$];
   int         n_vec;
   int         n_err;

   s65nllhs2ph_64x8 dut (
      .CLK   (clk),
      .RST   (rst),
      .CENA  (cena),
      .AA    (aa),
      .QA    (qa),
      .CENB  (cenb),
      .BWENB (bwenb),
      .AB    (ab),
      .DB    (db)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle of stimulus, driven on the falling edge; optionally queue an expected QA.
   task automatic cyc(input logic ca, input logic [5:0] a_a, input logic cb,
                      input logic [7:0] m, input logic [5:0] a_b, input logic [7:0] d,
                      input logic chk, input logic [7:0] e);
      @(negedge clk);
      cena  = ca;
      aa    = a_a;
      cenb  = cb;
      bwenb = m;
      ab    = a_b;
      db    = d;
      chk_en = chk;
      if (chk) exp_q.push_back(e);
   endtask

   task automatic rd(input logic [5:0] a, input logic [7:0] e);
      cyc(1'b1, a, 1'b0, 8'h00, 6'd0, 8'h00, 1'b1, e);
   endtask

   task automatic wr(input logic [5:0] a, input logic [7:0] m, input logic [7:0] d);
      cyc(1'b0, 6'd0, 1'b1, m, a, d, 1'b0, 8'h00);
   endtask

   task automatic idle();
      cyc(1'b0, 6'd0, 1'b0, 8'h00, 6'd0, 8'h00, 1'b0, 8'h00);
   endtask

   // Monitor: after each flagged edge, pop the expected value and compare with QA.
   initial begin
      logic [7:0] e;
      forever begin
         @(posedge clk);
         if (chk_en) begin
            #1;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL scoreboard_underflow: QA=%02h with no expected value queued", qa);
            end else begin
               e = exp_q.pop_front();
               if (qa !== e) begin
                  n_err++;
                  $display("FAIL qa_check t=%0t: QA=%02h expected %02h", $time, qa, e);
               end
            end
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_vec = 0; n_err = 0; chk_en = 1'b0;
      rst = 1'b1; cena = 1'b0; aa = '0; cenb = 1'b0; bwenb = '0; ab = '0; db = '0;
      #22;
      n_vec++;
      if (qa !== 8'h00) begin
         n_err++;
         $display("FAIL reset_qa: QA=%02h expected 00", qa);
      end
      @(negedge clk);
      rst = 1'b0;

      // Reset clear
      for (int i = 0; i < 64; i++) rd(6'(i), 8'h00);

      // Masked fill: only bit 0 is written
      for (int i = 0; i < 64; i++) wr(6'(i), 8'h01, 8'(i));
      for (int i = 0; i < 64; i++) rd(6'(i), 8'(i & 1));

      // Full-word write/read
      wr(6'd63, 8'hFF, 8'hA5);
      wr(6'd0,  8'hFF, 8'h3C);
      rd(6'd63, 8'hA5);
      rd(6'd0,  8'h3C);

      // Partial mask merges with existing contents: 0x01 | (0xF0 masked) at word 7
      wr(6'd7, 8'hF0, 8'hAB);
      rd(6'd7, 8'hA1);

      // Write enable gating: word 5 keeps 0x01
      cyc(1'b0, 6'd0, 1'b0, 8'hFF, 6'd5, 8'hFF, 1'b0, 8'h00);
      rd(6'd5, 8'h01);

      // Read enable gating: QA holds while AA moves
      cyc(1'b0, 6'd63, 1'b0, 8'h00, 6'd0, 8'h00, 1'b1, 8'h01);
      cyc(1'b0, 6'd0,  1'b0, 8'h00, 6'd0, 8'h00, 1'b1, 8'h01);
      cyc(1'b0, 6'd7,  1'b0, 8'h00, 6'd0, 8'h00, 1'b1, 8'h01);

      // Collision: read-before-write
      wr(6'd10, 8'hFF, 8'h11);
      cyc(1'b1, 6'd10, 1'b1, 8'hFF, 6'd10, 8'h22, 1'b1, 8'h11);
      rd(6'd10, 8'h22);

      // Mask of zero with write enabled is a no-op
      wr(6'd10, 8'h00, 8'hFF);
      rd(6'd10, 8'h22);

      // Async reset mid-stream
      rd(6'd63, 8'hA5);
      idle();
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (qa !== 8'h00) begin
         n_err++;
         $display("FAIL async_reset_qa: QA=%02h expected 00 before next edge", qa);
      end
      #1;
      rst = 1'b0;
      rd(6'd63, 8'h00);
      rd(6'd0,  8'h00);
      rd(6'd10, 8'h00);
      rd(6'd5,  8'h00);
      rd(6'd7,  8'h00);
      idle();
      idle();

      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/s65nllhs2ph_64x8.md
# s65nllhs2ph_64x8

Synchronous two-port register-file memory, 64 words × 8 bits, with one dedicated read port (A) and one dedicated write port (B) sharing a single clock. Port B writes under a per-bit write mask. Port A returns registered read data one cycle after the request. It is a drop-in storage macro for datapath buffers and small look-up tables, and has an asynchronous reset that clears both the array and the read register.

## Interface
- Bits, 8: data word width.
- Word_Depth, 64: number of addressable words.
- Add_Width, 6: address width; must satisfy 2^Add_Width ≥ Word_Depth.
- Wen_Width, 8: bit-write-mask width; always equals Bits.
- One clock; reset is asynchronous and active-high.
- CLK  in  1  single clock for both ports; all sampling on rising edge.
- RST  in  1  asynchronous active-high reset.
- CENA  in  1  read enable, port A, active-high.
- AA  in  Add_Width  read address.
- QA  out  Bits  registered read data.
- CENB  in  1  write enable, port B, active-high.
- BWENB  in  Wen_Width  per-bit write mask, active-high (bit k=1 writes data bit k).
- AB  in  Add_Width  write address.
- DB  in  Bits  write data.

## Operation
- Storage: Word_Depth × Bits array.
- Reset (RST=1): all array words are 0 and QA=0, immediately and independent of CLK. The reset condition holds while RST is high. All inputs are ignored during reset.
- Write, on a rising CLK edge with CENB=1:
  - For each bit k, mem[AB][k] ← DB[k] if BWENB[k]=1; otherwise bit k is unchanged.
  - BWENB=0 with CENB=1 is a legal no-op.
- CENB=0: no write, regardless of BWENB, AB or DB.
- Read, on a rising CLK edge with CENA=1: QA ← mem[AA].
- CENA=0: QA holds its previous value.
- Out-of-range addresses (≥ Word_Depth, only possible if Word_Depth < 2^Add_Width):
  - Writes are ignored.
  - Reads load QA with 0.
- Same-edge collision (CENA=1, CENB=1, AA=AB): read-before-write. QA gets the pre-write contents, and the array gets the masked update. Back-to-back reads therefore return the new data one edge later.
- Ports A and B are fully independent otherwise: one read and one write may complete on every edge.

## Timing
- Read latency: 1 cycle. Data for the address presented at edge N is valid on QA after edge N until the next enabled read edge.
- Write latency: the array is updated at edge N. A read of the same address at edge N+1 or later returns the new data.
- No handshake: there are no stalls and no busy flags. Every enabled request completes at its edge.
- Reset assertion mid-operation: a write pending at the same edge is lost, and QA is forced to 0 asynchronously.
- Release of RST is synchronized by the user. The first enabled edge after deassertion operates normally.
- Output reset values: QA=0.

## Test plan
- **Reset clear:** assert RST, release, then read addresses 0..63 with CENA=1 -> QA=0x00 one cycle after each address.
- **Masked fill:** with CENB=1 and BWENB=8'h01, write AB=i, DB=i for i=0..63; then read 0..63 -> QA = i & 1 (only bit 0 written; upper bits remain 0 from reset).
- **Full-word write/read:** BWENB=8'hFF, write DB=8'hA5 to AB=63 and DB=8'h3C to AB=0 -> reads return 0xA5 and 0x3C respectively, one cycle after the address is presented.
- **Enable gating:**
  - CENB=0 with BWENB=8'hFF and DB=8'hFF at AB=5 -> a later read of address 5 still returns its prior value.
  - CENA=0 -> QA holds its last value while AA changes.
- **Collision:** mem[10]=0x11; on the same edge write DB=0x22 with BWENB=8'hFF to AB=10 and read AA=10 -> QA=0x11. The next read of address 10 -> 0x22.
- **Async reset mid-stream:** during streaming reads with QA=0xA5, pulse RST between clock edges -> QA drops to 0 before the next edge. Subsequent reads return 0 for all previously written addresses.
